ysyx_2022040010_pipe_adder: RTL and testbench

//  Parametrised, pipelined integer add/sub unit for the EXU datapath.
//  The carry chain is split into STAGES equal slices, with one slice resolved per pipeline stage.
//  It supports RV64 word ops (low-half compute + sign-extend), subtract/borrow, signed overflow and zero flags.
//  It uses a valid/ready handshake on both sides, plus flush and a tag passthrough for the issuing uop.

---
 rtl/ysyx_2022040010_pipe_adder.sv | 144 ++++++++++++++
 tb/tb_ysyx_2022040010_pipe_adder.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_2022040010_pipe_adder.sv
// Pipelined add/sub unit: the carry chain is cut into STAGES equal slices, one resolved per stage.
// Valid/ready on both sides with flush, tag passthrough and RV64 word-op support.
module ysyx_2022040010_pipe_adder #(
    parameter int WIDTH   = 64,
    parameter int STAGES  = 2,
    parameter int TAG_W   = 4,
    parameter int WORD_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_c,
    input  logic             in_sub,
    input  logic             in_word,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s,
    output logic             out_c,
    output logic             out_ovf,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);
    localparam int SW = WIDTH / STAGES;
    localparam int H  = WIDTH / 2;
    localparam int L  = STAGES - 1;

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] ld;

    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic             cy_q  [STAGES];
    logic             w_q   [STAGES];
    logic [TAG_W-1:0] tag_q [STAGES];

    logic [WIDTH-1:0] a_d   [STAGES];
    logic [WIDTH-1:0] b_d   [STAGES];
    logic [WIDTH-1:0] s_d   [STAGES];
    logic             cy_d  [STAGES];
    logic             w_d   [STAGES];
    logic [TAG_W-1:0] tag_d [STAGES];
    logic [SW:0]      sl    [STAGES];

    logic             word_in;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] res;

    assign word_in = (WORD_EN != 0) && in_word;
    assign b_eff   = in_sub ? ~in_b : in_b;
    assign a_in    = word_in ? {{(WIDTH-H){1'b0}}, in_a[H-1:0]}  : in_a;
    assign b_in    = word_in ? {{(WIDTH-H){1'b0}}, b_eff[H-1:0]} : b_eff;

    // Ready chain runs back from out_ready so bubbles collapse.
    always_comb begin
        adv = '0;
        ld  = '0;
        adv[L] = v_q[L] && out_ready;
        for (int unsigned j = 1; j < STAGES; j++) begin
            adv[L-j] = v_q[L-j] && (!v_q[L-j+1] || adv[L-j+1]);
        end
        in_ready = rst_n && !flush && (!v_q[0] || adv[0]);
        ld[0]    = in_valid && in_ready;
        for (int unsigned k = 1; k < STAGES; k++) begin
            ld[k] = adv[k-1];
        end
    end

    always_comb begin
        sl[0]    = {1'b0, a_in[SW-1:0]} + {1'b0, b_in[SW-1:0]} + {{SW{1'b0}}, in_c ^ in_sub};
        a_d[0]   = a_in;
        b_d[0]   = b_in;
        w_d[0]   = word_in;
        tag_d[0] = in_tag;
        s_d[0]   = '0;
        s_d[0][SW-1:0] = sl[0][SW-1:0];
        cy_d[0]  = sl[0][SW];
        for (int unsigned k = 1; k < STAGES; k++) begin
            sl[k]    = {1'b0, a_q[k-1][k*SW +: SW]} + {1'b0, b_q[k-1][k*SW +: SW]}
                     + {{SW{1'b0}}, cy_q[k-1]};
            a_d[k]   = a_q[k-1];
            b_d[k]   = b_q[k-1];
            w_d[k]   = w_q[k-1];
            tag_d[k] = tag_q[k-1];
            s_d[k]   = s_q[k-1];
            s_d[k][k*SW +: SW] = sl[k][SW-1:0];
            cy_d[k]  = sl[k][SW];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                s_q[k]   <= '0;
                cy_q[k]  <= 1'b0;
                w_q[k]   <= 1'b0;
                tag_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                if (flush)       v_q[k] <= 1'b0;
                else if (ld[k])  v_q[k] <= 1'b1;
                else if (adv[k]) v_q[k] <= 1'b0;
                if (ld[k]) begin
                    a_q[k]   <= a_d[k];
                    b_q[k]   <= b_d[k];
                    s_q[k]   <= s_d[k];
                    cy_q[k]  <= cy_d[k];
                    w_q[k]   <= w_d[k];
                    tag_q[k] <= tag_d[k];
                end
            end
        end
    end

    // Word ops zero the upper operand halves, so sum bit H is exactly the carry into bit H.
    always_comb begin
        res     = s_q[L];
        out_c   = cy_q[L];
        out_ovf = (a_q[L][WIDTH-1] == b_q[L][WIDTH-1]) && (s_q[L][WIDTH-1] != a_q[L][WIDTH-1]);
        if (w_q[L]) begin
            res     = {{(WIDTH-H){s_q[L][H-1]}}, s_q[L][H-1:0]};
            out_c   = s_q[L][H];
            out_ovf = (a_q[L][H-1] == b_q[L][H-1]) && (s_q[L][H-1] != a_q[L][H-1]);
        end
    end

    assign out_valid = v_q[L];
    assign out_s     = res;
    assign out_zero  = v_q[L] && (res == '0);
    assign out_tag   = tag_q[L];

endmodule

// File: tb/tb_ysyx_2022040010_pipe_adder.sv
// Bench for ysyx_2022040010_pipe_adder: four configurations share one stimulus stream,
// each with its own scoreboard fed by an independent reference model.
module tb_ysyx_2022040010_pipe_adder;
    localparam int N  = 4;
    localparam int S0 = 2;

    typedef struct packed {
        logic [63:0] s;
        logic        c;
        logic        ovf;
        logic        zero;
        logic [3:0]  tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_c = 1'b0;
    logic        in_sub = 1'b0;
    logic        in_word = 1'b0;
    logic        out_ready = 1'b0;
    logic [63:0] in_a = '0;
    logic [63:0] in_b = '0;
    logic [3:0]  in_tag = '0;

    logic        rdy [N];
    logic        ov  [N];
    logic [63:0] os  [N];
    logic        oc  [N];
    logic        oo  [N];
    logic        oz  [N];
    logic [3:0]  ot  [N];
    logic [47:0] os48;

    int          wid [N] = '{64, 64, 48, 64};
    exp_t        sb  [N][$];
    logic [3:0]  seen0 [$];
    logic        acc0 = 1'b0;
    logic        rdy0_s = 1'b0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    ysyx_2022040010_pipe_adder #(.WIDTH(64), .STAGES(2), .TAG_W(4), .WORD_EN(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy[0]),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_sub(in_sub), .in_word(in_word), .in_tag(in_tag),
        .out_valid(ov[0]), .out_ready(out_ready), .out_s(os[0]), .out_c(oc[0]), .out_ovf(oo[0]),
        .out_zero(oz[0]), .out_tag(ot[0]));

    ysyx_2022040010_pipe_adder #(.WIDTH(64), .STAGES(1), .TAG_W(4), .WORD_EN(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy[1]),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_sub(in_sub), .in_word(in_word), .in_tag(in_tag),
        .out_valid(ov[1]), .out_ready(out_ready), .out_s(os[1]), .out_c(oc[1]), .out_ovf(oo[1]),
        .out_zero(oz[1]), .out_tag(ot[1]));

    ysyx_2022040010_pipe_adder #(.WIDTH(48), .STAGES(3), .TAG_W(4), .WORD_EN(1)) u_w48 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy[2]),
        .in_a(in_a[47:0]), .in_b(in_b[47:0]), .in_c(in_c), .in_sub(in_sub), .in_word(in_word),
        .in_tag(in_tag), .out_valid(ov[2]), .out_ready(out_ready), .out_s(os48), .out_c(oc[2]),
        .out_ovf(oo[2]), .out_zero(oz[2]), .out_tag(ot[2]));
    assign os[2] = {16'h0, os48};

    ysyx_2022040010_pipe_adder #(.WIDTH(64), .STAGES(8), .TAG_W(4), .WORD_EN(1)) u_s8 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy[3]),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_sub(in_sub), .in_word(in_word), .in_tag(in_tag),
        .out_valid(ov[3]), .out_ready(out_ready), .out_s(os[3]), .out_c(oc[3]), .out_ovf(oo[3]),
        .out_zero(oz[3]), .out_tag(ot[3]));

    // Monolithic reference: one wide add on masked operands.
    function automatic exp_t ref_model(input logic [63:0] a, input logic [63:0] b, input logic c,
                                       input logic sub, input logic word, input int w);
        exp_t        e;
        logic [64:0] sum;
        logic [63:0] m, hm, aa, bb, r;
        int          h;
        m  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        h  = w / 2;
        hm = (64'd1 << h) - 64'd1;
        aa = a & m;
        bb = (sub ? ~b : b) & m;
        if (word) begin
            aa = aa & hm;
            bb = bb & hm;
        end
        sum = {1'b0, aa} + {1'b0, bb} + {64'b0, c ^ sub};
        if (word) begin
            r     = sum[h-1] ? ((sum[63:0] & hm) | (m & ~hm)) : (sum[63:0] & hm);
            e.c   = sum[h];
            e.ovf = (aa[h-1] == bb[h-1]) && (r[h-1] != aa[h-1]);
        end else begin
            r     = sum[63:0] & m;
            e.c   = sum[w];
            e.ovf = (aa[w-1] == bb[w-1]) && (r[w-1] != aa[w-1]);
        end
        e.s    = r;
        e.zero = (r == 64'd0);
        e.tag  = '0;
        return e;
    endfunction

    // One clock: sample handshakes 1ns after inputs change, score them, advance to next negedge.
    task automatic tick();
        exp_t e;
        exp_t got;
        #1;
        acc0   = 1'b0;
        rdy0_s = rdy[0];
        for (int i = 0; i < N; i++) begin
            if (ov[i] && out_ready) begin
                got = {os[i], oc[i], oo[i], oz[i], ot[i]};
                checks++;
                if (sb[i].size() == 0) begin
                    errors++;
                    $display("FAIL sb%0d_spurious: got s=%h tag=%0d, required no output", i, os[i], ot[i]);
                end else begin
                    e = sb[i].pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL sb%0d_result: got s=%h c=%b ovf=%b zero=%b tag=%0d, required s=%h c=%b ovf=%b zero=%b tag=%0d",
                                 i, got.s, got.c, got.ovf, got.zero, got.tag, e.s, e.c, e.ovf, e.zero, e.tag);
                    end
                end
                if (i == 0) seen0.push_back(ot[0]);
            end
            if (in_valid && rdy[i]) begin
                e     = ref_model(in_a, in_b, in_c, in_sub, in_word, wid[i]);
                e.tag = in_tag;
                sb[i].push_back(e);
                if (i == 0) acc0 = 1'b1;
            end
        end
        if (flush) begin
            for (int i = 0; i < N; i++) sb[i].delete();
        end
        @(negedge clk);
    endtask

    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic c, input logic sub,
                        input logic word, input logic [3:0] tag);
        int n = 0;
        in_a = a; in_b = b; in_c = c; in_sub = sub; in_word = word; in_tag = tag;
        in_valid = 1'b1;
        do begin
            tick();
            n++;
        end while (!acc0 && n < 50);
        in_valid = 1'b0;
        checks++;
        if (!acc0) begin
            errors++;
            $display("FAIL accept_timeout: got no accept in %0d cycles, required accept", n);
        end
    endtask

    task automatic wait_out0(output int n);
        n = 0;
        while (!ov[0] && n < 50) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            checks++;
            if ({rdy[i], ov[i], os[i], oc[i], oo[i], oz[i], ot[i]} !== '0) begin
                errors++;
                $display("FAIL reset_state%0d: got rdy=%b v=%b s=%h c=%b ovf=%b zero=%b tag=%0d, required all 0",
                         i, rdy[i], ov[i], os[i], oc[i], oo[i], oz[i], ot[i]);
            end
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_add_full();
        int n;
        out_ready = 1'b1;
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b0, 4'd1);
        wait_out0(n);
        checks++;
        if (n != S0 - 1) begin
            errors++;
            $display("FAIL add_latency: got %0d extra edges, required %0d", n, S0 - 1);
        end
        checks++;
        if ({os[0], oc[0], oo[0], oz[0], ot[0]} !== {64'h0, 1'b1, 1'b0, 1'b1, 4'd1}) begin
            errors++;
            $display("FAIL add_wrap: got s=%h c=%b ovf=%b zero=%b tag=%0d, required s=0 c=1 ovf=0 zero=1 tag=1",
                     os[0], oc[0], oo[0], oz[0], ot[0]);
        end
        tick();
    endtask

    task automatic test_word();
        int n;
        send(64'h0000_0000_7FFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b1, 4'd2);
        wait_out0(n);
        checks++;
        if ({os[0], oc[0], oo[0], oz[0]} !== {64'hFFFF_FFFF_8000_0000, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL word_add: got s=%h c=%b ovf=%b zero=%b, required s=ffffffff80000000 c=0 ovf=1 zero=0",
                     os[0], oc[0], oo[0], oz[0]);
        end
        tick();
    endtask

    task automatic test_sub();
        int n;
        send(64'd5, 64'd7, 1'b0, 1'b1, 1'b0, 4'd3);
        wait_out0(n);
        checks++;
        if ({os[0], oc[0]} !== {64'hFFFF_FFFF_FFFF_FFFE, 1'b0}) begin
            errors++;
            $display("FAIL sub_neg: got s=%h c=%b, required s=fffffffffffffffe c=0", os[0], oc[0]);
        end
        tick();
        send(64'd7, 64'd5, 1'b1, 1'b1, 1'b0, 4'd4);
        wait_out0(n);
        checks++;
        if ({os[0], oc[0], oo[0]} !== {64'd1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL sub_borrow: got s=%h c=%b ovf=%b, required s=1 c=1 ovf=0", os[0], oc[0], oo[0]);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int idx = 0;
        int cyc = 0;
        seen0.delete();
        while (idx < 8 && cyc < 60) begin
            out_ready = !(cyc >= 4 && cyc < 7);
            in_a = 64'h0123_4567_89AB_CDEF * 64'(idx + 1);
            in_b = 64'hFEDC_BA98_7654_3210 + 64'(idx);
            in_c = idx[0]; in_sub = idx[1]; in_word = idx[2];
            in_tag = 4'(idx);
            in_valid = 1'b1;
            tick();
            if (cyc >= 4 && cyc < 7) begin
                checks++;
                if (rdy0_s !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_ready cyc%0d: got in_ready=%b, required 0", cyc, rdy0_s);
                end
            end
            if (acc0) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 40 && sb[0].size() != 0; k++) tick();
        checks++;
        if (seen0.size() != 8) begin
            errors++;
            $display("FAIL stream_count: got %0d results, required 8", seen0.size());
        end
        for (int i = 0; i < 8 && i < seen0.size(); i++) begin
            checks++;
            if (seen0[i] !== 4'(i)) begin
                errors++;
                $display("FAIL stream_order%0d: got tag %0d, required %0d", i, seen0[i], i);
            end
        end
    endtask

    task automatic test_flush();
        int cnt = 0;
        for (int k = 0; k < 20; k++) tick();
        out_ready = 1'b0;
        send(64'd10, 64'd20, 1'b0, 1'b0, 1'b0, 4'd5);
        send(64'd30, 64'd40, 1'b0, 1'b0, 1'b0, 4'd6);
        flush = 1'b1;
        in_valid = 1'b1;
        in_a = 64'd50; in_tag = 4'd7;
        tick();
        checks++;
        if (rdy0_s !== 1'b0 || acc0 !== 1'b0) begin
            errors++;
            $display("FAIL flush_accept: got in_ready=%b accepted=%b, required 0 0", rdy0_s, acc0);
        end
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (ov[0] !== 1'b0) begin
            errors++;
            $display("FAIL flush_valid: got out_valid=%b, required 0", ov[0]);
        end
        for (int k = 0; k < 12; k++) begin
            if (ov[0]) cnt++;
            tick();
        end
        checks++;
        if (cnt != 0) begin
            errors++;
            $display("FAIL flush_leak: got %0d results after flush, required 0", cnt);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        send(64'd3, 64'd4, 1'b0, 1'b0, 1'b0, 4'd9);
        tick();
        checks++;
        if ({ov[0], os[0]} !== {1'b1, 64'd7}) begin
            errors++;
            $display("FAIL pre_reset: got v=%b s=%h, required v=1 s=7", ov[0], os[0]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rdy[0], ov[0], os[0], oc[0], oo[0], oz[0], ot[0]} !== '0) begin
            errors++;
            $display("FAIL async_reset: got rdy=%b v=%b s=%h c=%b ovf=%b zero=%b tag=%0d, required all 0",
                     rdy[0], ov[0], os[0], oc[0], oo[0], oz[0], ot[0]);
        end
        for (int i = 0; i < N; i++) sb[i].delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [63:0] pat [4];
        pat[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        pat[1] = 64'h0000_0000_7FFF_FFFF;
        pat[2] = 64'h8000_0000_0000_0000;
        pat[3] = 64'h0000_7FFF_FFFF_FFFF;
        for (int k = 0; k < 400; k++) begin
            in_valid  = ($urandom_range(9) < 7);
            out_ready = ($urandom_range(3) != 0);
            in_a = ($urandom_range(3) == 0) ? pat[$urandom_range(3)] : {$urandom, $urandom};
            in_b = ($urandom_range(3) == 0) ? pat[$urandom_range(3)] : {$urandom, $urandom};
            in_c = $urandom_range(1);
            in_sub = $urandom_range(1);
            in_word = $urandom_range(1);
            in_tag = 4'($urandom);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 40; k++) tick();
        for (int i = 0; i < N; i++) begin
            checks++;
            if (sb[i].size() != 0) begin
                errors++;
                $display("FAIL drain%0d: got %0d results still owed, required 0", i, sb[i].size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_full();
        test_word();
        test_sub();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
